char_readout: RTL



---
 rtl/char_readout_pkg.sv | 21 ++
 rtl/char_readout_if.sv | 23 ++
 rtl/char_readout_vram_addr_counter.sv | 60 ++++++
 rtl/char_readout.sv | 118 +++++++++++
 4 files changed

// File: rtl/char_readout_pkg.sv
// Shared constants and state encoding for the character readout path.
// The phase constants are also used by the pixel generator.
package char_readout_pkg;

  localparam int unsigned DEF_COLS   = 80;
  localparam int unsigned DEF_ROWS   = 30;
  localparam int unsigned DEF_ADDR_W = 13;

  // Cell phases: reads issue at 1/5, pixel generator latches at 3/7.
  localparam logic [2:0] CHAR_ISSUE = 3'd1;
  localparam logic [2:0] ATTR_ISSUE = 3'd5;
  localparam logic [2:0] CHAR_PHASE = 3'd3;
  localparam logic [2:0] ATTR_PHASE = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } stateT;

endpackage

// File: rtl/char_readout_if.sv
// VRAM read port plus the readout stream towards the pixel generator.
interface char_readout_if import char_readout_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              vramRdEn;
  logic [ADDR_W-1:0] vramRdAddr;
  logic [7:0]        vramRdData;
  logic [7:0]        readoutData;
  logic [2:0]        readoutCount;
  logic              active;

  modport master (
    output vramRdEn, vramRdAddr, readoutData, readoutCount, active,
    input  vramRdData
  );

  modport slave (
    input  vramRdEn, vramRdAddr, readoutData, readoutCount, active,
    output vramRdData
  );

endinterface

// File: rtl/char_readout_vram_addr_counter.sv
// VRAM address counters: row base, column address and column index, built
// from adders only so no multiplier is needed for the cell address.
module char_readout_vram_addr_counter import char_readout_pkg::*; #(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic              rowEnd,
  output logic [ADDR_W-1:0] colAddr,
  output logic              lastCol
);

  localparam int unsigned       ColW        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ADDR_W-1:0] RowStride   = ADDR_W'(2 * COLS);
  localparam logic [ADDR_W-1:0] LastRowBase = ADDR_W'(2 * COLS * (ROWS - 1));
  localparam logic [ColW-1:0]   LastColIdx  = ColW'(COLS - 1);

  logic [ADDR_W-1:0] rowBaseQ, rowBaseD;
  logic [ADDR_W-1:0] colAddrQ, colAddrD;
  logic [ColW-1:0]   colQ, colD;

  always_comb begin
    rowBaseD = rowBaseQ;
    colAddrD = colAddrQ;
    colD     = colQ;
    if (clear) begin
      rowBaseD = '0;
    end else if (rowEnd) begin
      rowBaseD = (rowBaseQ == LastRowBase) ? '0 : rowBaseQ + RowStride;
    end
    if (load) begin
      colAddrD = rowBaseQ;
      colD     = '0;
    end else if (step) begin
      colAddrD = colAddrQ + ADDR_W'(2);
      colD     = colQ + ColW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rowBaseQ <= '0;
      colAddrQ <= '0;
      colQ     <= '0;
    end else begin
      rowBaseQ <= rowBaseD;
      colAddrQ <= colAddrD;
      colQ     <= colD;
    end
  end

  assign colAddr = colAddrQ;
  assign lastCol = (colQ == LastColIdx);

endmodule

// File: rtl/char_readout.sv
// Character/attribute fetch sequencer: reads one byte pair per 8-cycle cell
// from VRAM and streams it to the pixel generator.
module char_readout import char_readout_pkg::*; #(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  lineStart,
  input  logic                  frameStart,
  input  logic [3:0]            vCount,
  char_readout_if.master        bus
);

  localparam logic [2:0] CountHold = 3'd7;

  stateT             stateQ, stateD;
  logic [2:0]        countQ, countD;
  logic [3:0]        lineRowQ, lineRowD;
  logic [7:0]        dataQ;
  logic              load, step, rowEnd, clearRow;
  logic              lastCol;
  logic [ADDR_W-1:0] colAddr;
  logic              issueChar, issueAttr, capture;

  char_readout_vram_addr_counter #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (clearRow),
    .load    (load),
    .step    (step),
    .rowEnd  (rowEnd),
    .colAddr (colAddr),
    .lastCol (lastCol)
  );

  always_comb begin
    stateD   = stateQ;
    countD   = countQ;
    lineRowD = lineRowQ;
    load     = 1'b0;
    step     = 1'b0;
    rowEnd   = 1'b0;
    clearRow = 1'b0;
    if (frameStart) begin
      stateD   = StIdle;
      countD   = CountHold;
      clearRow = 1'b1;
    end else begin
      unique case (stateQ)
        StIdle: begin
          countD = CountHold;
          if (lineStart) begin
            stateD   = StFetch;
            countD   = 3'd0;
            lineRowD = vCount;
            load     = 1'b1;
          end
        end
        StFetch: begin
          countD = countQ + 3'd1;
          if (countQ == ATTR_PHASE) begin
            step = 1'b1;
            if (lastCol) begin
              stateD = StDrain;
              rowEnd = (lineRowQ == 4'd15);
            end
          end
        end
        StDrain: begin
          countD = countQ + 3'd1;
          if (countQ == 3'd7) begin
            stateD = StIdle;
            countD = CountHold;
          end
        end
        default: begin
          stateD = StIdle;
          countD = CountHold;
        end
      endcase
    end
  end

  assign issueChar = (stateQ == StFetch) && (countQ == CHAR_ISSUE);
  assign issueAttr = (stateQ == StFetch) && (countQ == ATTR_ISSUE);
  // VRAM data arrives the cycle after issue; register it so it is valid at the latch phase.
  assign capture   = (stateQ == StFetch) && !frameStart &&
                     ((countQ == CHAR_PHASE - 3'd1) || (countQ == ATTR_PHASE - 3'd1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stateQ   <= StIdle;
      countQ   <= CountHold;
      lineRowQ <= '0;
      dataQ    <= '0;
    end else begin
      stateQ   <= stateD;
      countQ   <= countD;
      lineRowQ <= lineRowD;
      if (capture) begin
        dataQ <= bus.vramRdData;
      end
    end
  end

  assign bus.vramRdEn     = issueChar | issueAttr;
  assign bus.vramRdAddr   = issueAttr ? colAddr + ADDR_W'(1) : (issueChar ? colAddr : '0);
  assign bus.readoutData  = dataQ;
  assign bus.readoutCount = countQ;
  assign bus.active       = (stateQ == StFetch);

endmodule
